// File: rtl/inst_mem.sv
// inst_mem: single-port instruction memory with a registered fetch port and a
// byte-serial big-endian program loader that writes words sequentially from 0.
// Optional feature macro: INST_MEM_BOUNDS_CHECK_EN (flags fetches whose address
// bits above the memory range are nonzero; otherwise those bits alias).
module inst_mem #(
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ce,
   input  logic [31:0]           addr,
   output logic [31:0]           inst,
   output logic                  inst_valid,
   output logic                  fetch_err,
   input  logic                  ld_start,
   input  logic                  ld_stop,
   input  logic                  ld_valid,
   input  logic [7:0]            ld_byte,
   output logic                  ld_ready,
   output logic                  ld_busy,
   output logic [ADDR_WIDTH:0]   ld_words
);

   localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
   localparam int unsigned WCNT_W = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_WRITE   = 2'd2
   } state_e;

   logic [31:0]           mem [DEPTH];

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [1:0]            cnt_q, cnt_d;
   logic [31:0]           sr_q, sr_d;
   logic [WCNT_W-1:0]     words_q, words_d;
   logic                  ld_ready_q, ld_busy_q;
   logic                  we_c;

   logic [31:0]           inst_q;
   logic                  inst_valid_q, fetch_err_q;

   logic [ADDR_WIDTH-1:0] idx_c;
   logic                  misalign_c, oor_c, err_c;

   // Fetch address decode: word index, alignment and range
   assign idx_c      = addr[ADDR_WIDTH+1:2];
   assign misalign_c = |addr[1:0];
`ifdef INST_MEM_BOUNDS_CHECK_EN
   assign oor_c      = |addr[31:ADDR_WIDTH+2];
`else
   logic unused_addr_hi;
   assign unused_addr_hi = ^addr[31:ADDR_WIDTH+2];
   assign oor_c          = 1'b0;
`endif
   assign err_c = misalign_c | oor_c;

   // Registered fetch; same-edge read sees the pre-write contents
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inst_q       <= '0;
         inst_valid_q <= 1'b0;
         fetch_err_q  <= 1'b0;
      end else if (ce) begin
         inst_q       <= err_c ? 32'd0 : mem[idx_c];
         inst_valid_q <= 1'b1;
         fetch_err_q  <= err_c;
      end else begin
         inst_q       <= '0;
         inst_valid_q <= 1'b0;
         fetch_err_q  <= 1'b0;
      end
   end

   // Loader write port; memory contents are deliberately not reset
   always_ff @(posedge clk) begin
      if (we_c) begin
         mem[ptr_q] <= sr_q;
      end
   end

   // Loader state register and status outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         cnt_q      <= '0;
         sr_q       <= '0;
         words_q    <= '0;
         ld_ready_q <= 1'b0;
         ld_busy_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         sr_q       <= sr_d;
         words_q    <= words_d;
         ld_ready_q <= (state_d == S_COLLECT);
         ld_busy_q  <= (state_d != S_IDLE);
      end
   end

   // Loader next-state: start restarts from word 0 in any state, stop ends a load
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      words_d = words_q;
      we_c    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (ld_start) begin
               ptr_d   = '0;
               cnt_d   = '0;
               sr_d    = '0;
               words_d = '0;
               state_d = S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (ld_start) begin
               ptr_d   = '0;
               cnt_d   = '0;
               sr_d    = '0;
               words_d = '0;
            end else if (ld_stop) begin
               cnt_d   = '0;
               sr_d    = '0;
               state_d = S_IDLE;
            end else if (ld_valid) begin
               sr_d  = {sr_q[23:0], ld_byte};
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  state_d = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            if (ld_start) begin
               ptr_d   = '0;
               cnt_d   = '0;
               sr_d    = '0;
               words_d = '0;
               state_d = S_COLLECT;
            end else begin
               we_c    = 1'b1;
               ptr_d   = ptr_q + ADDR_WIDTH'(1);
               words_d = words_q + WCNT_W'(1);
               cnt_d   = '0;
               if (ld_stop || (ptr_q == LAST_PTR)) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_COLLECT;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign inst       = inst_q;
   assign inst_valid = inst_valid_q;
   assign fetch_err  = fetch_err_q;
   assign ld_ready   = ld_ready_q;
   assign ld_busy    = ld_busy_q;
   assign ld_words   = words_q;

endmodule

// File: doc/inst_mem.md
# inst_mem

Single-port instruction memory that answers the fetch stage's `pc`/`ce` requests, returning one 32-bit instruction per enabled cycle with one-cycle registered latency. It also contains a byte-serial program loader, a small state machine that assembles incoming bytes into big-endian words and writes them sequentially from word 0. The block sits between the PC register (fetch initiator) and the IF/ID pipeline register; the loader side is driven by a host or boot interface.

## Interface
- `ADDR_WIDTH`, 10, word-address width; depth = 2^ADDR_WIDTH words (default 4 KB).
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `ce` in 1: fetch enable from the PC stage.
- `addr` in 32: fetch byte address. Word index = `addr[ADDR_WIDTH+1:2]`.
- `inst` out 32: fetched instruction.
- `inst_valid` out 1: `inst` holds the result of an enabled fetch.
- `fetch_err` out 1: the last enabled fetch was misaligned or out of range.
- `ld_start` in 1: one-cycle pulse that starts a load at word 0.
- `ld_stop` in 1: one-cycle pulse that ends a load.
- `ld_valid` in 1: `ld_byte` is valid.
- `ld_byte` in 8: program byte. The most significant byte of each word arrives first.
- `ld_ready` out 1: the loader accepts a byte this cycle.
- `ld_busy` out 1: the loader is not IDLE.
- `ld_words` out ADDR_WIDTH+1: number of words written since the last `ld_start`.

## Operation
- **Fetch.** The fetch path is registered. At each rising edge with `ce`=1, the block sets `inst` to `mem[index]`, sets `inst_valid` to 1, and sets `fetch_err` to (`addr[1:0]`≠0) or out-of-range.
  - An error fetch returns `inst`=0 (NOP).
  - With `ce`=0, the block sets `inst`=0, `inst_valid`=0 and `fetch_err`=0.
- **Loader FSM.** The loader has three states: IDLE, COLLECT and WRITE.
  - IDLE: `ld_ready`=0. On `ld_start`, it clears the write pointer, byte count, shift register and `ld_words`, then moves to COLLECT.
  - COLLECT: `ld_ready`=1. When `ld_valid`&`ld_ready`, the shift register becomes {sr[23:0], `ld_byte`} and the byte count increments. The cycle that accepts the 4th byte moves to WRITE.
  - WRITE: `ld_ready`=0 for exactly one cycle. The block writes `mem[ptr]` with the shift register, increments `ptr` and `ld_words`, and clears the byte count.
    - The next state is COLLECT if `ptr`+1 < depth; otherwise it is IDLE (memory full).
- **Stop and restart.**
  - `ld_stop` in COLLECT moves to IDLE and discards partial bytes.
  - `ld_stop` in WRITE still completes the write, then moves to IDLE.
  - `ld_start` in COLLECT or WRITE restarts at word 0. A pending WRITE is dropped.
- **Fetch during load.** Fetches are always served while loading.
  - When a fetch and a write target the same word in the same cycle, the fetch returns the old contents (read-before-write).
- **Reset.** Reset is asynchronous, with `rst`=0 forcing:
  - `inst`=0, `inst_valid`=0, `fetch_err`=0;
  - FSM to IDLE, so `ld_ready`=0 and `ld_busy`=0;
  - `ptr`=0, `ld_words`=0.
  - Memory contents are not reset. A reset in the middle of a load abandons it; words already written remain.

## Timing
- Fetch latency is 1 cycle: an address presented in cycle N appears on `inst` after edge N+1.
- Throughput is one fetch per cycle with no stalls.
- The loader accepts at most 4 bytes per 5 cycles (4 COLLECT cycles plus 1 WRITE cycle).
- The write commits at the WRITE-cycle edge. A fetch of that word in the next cycle returns the new data.
- `ld_busy` rises the cycle after `ld_start` and falls the cycle after the IDLE transition.

## Configuration
- `INST_MEM_BOUNDS_CHECK_EN`
  - **Defined:** an address with any nonzero bit in `addr[31:ADDR_WIDTH+2]` is out of range. Such a fetch sets `fetch_err`=1 and returns `inst`=0.
  - **Undefined:** the upper address bits are ignored, so addresses alias modulo depth. Out-of-range never flags; `fetch_err` reflects misalignment only.

## Test plan
- **Reset.** Assert `rst`=0 in the middle of any state, then release → `inst`=0, `inst_valid`=0, `ld_busy`=0, `ld_words`=0.
- **Load then fetch.** `ld_start`, then bytes 3C,01,12,34,34,21,00,FF, then `ld_stop` → `ld_words`=2. Fetch `addr`=0 gives `inst`=3C011234 one cycle later; `addr`=4 gives 342100FF; `inst_valid`=1 both times.
- **Partial word discarded.** Load 5 bytes, then `ld_stop` → `ld_words`=1 and word 1 is unchanged.
- **Misaligned fetch.** `ce`=1, `addr`=2 → `fetch_err`=1, `inst`=0.
- **Out of range.** `addr`=0x00001000 with the default `ADDR_WIDTH`:
  - With the macro defined → `fetch_err`=1, `inst`=0.
  - Without it → returns word 0 and `fetch_err`=0.
- **Read-before-write and full memory.**
  - A fetch of word k during its WRITE cycle returns the old value; the fetch in the next cycle returns the new value.
  - Loading 2^ADDR_WIDTH words → FSM returns to IDLE and `ld_words`=1024.
